// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared pipeline definitions: the stall FSM state, ID/EXE control word layout,
// and stage-control bundles that the stall sequencer resolves between.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } stall_state_e;

  localparam int DEF_MEM_TIMEOUT = 255;

  // ID/EXE control word. A bubble loads NOP_CTRL so nothing is written back
  // and memory is never touched by the squashed slot.
  typedef struct packed {
    logic       wb_en;
    logic       mem_r;
    logic       mem_w;
    logic [3:0] exe_cmd;
    logic       br_en;
    logic       imm_en;
  } id_exe_ctrl_t;

  localparam int           CTRL_W   = $bits(id_exe_ctrl_t);
  localparam id_exe_ctrl_t NOP_CTRL = '0;

  // Per-cycle stage controls driven into the pipeline registers.
  typedef struct packed {
    logic freeze_pc;
    logic freeze_if_id;
    logic bubble_id_exe;
    logic flush_if_id;
    logic freeze_back;
  } stage_ctrl_t;

  // Memory wait / halt: the whole pipe holds still.
  localparam stage_ctrl_t CTRL_IDLE   = '0;
  localparam stage_ctrl_t CTRL_FREEZE = '{freeze_pc: 1'b1, freeze_if_id: 1'b1,
                                          bubble_id_exe: 1'b0, flush_if_id: 1'b0,
                                          freeze_back: 1'b1};
  // Taken branch: squash both wrong-path instructions, fetch the target.
  localparam stage_ctrl_t CTRL_FLUSH  = '{freeze_pc: 1'b0, freeze_if_id: 1'b0,
                                          bubble_id_exe: 1'b1, flush_if_id: 1'b1,
                                          freeze_back: 1'b0};
  // RAW hazard: hold the front end, insert one bubble into EXE.
  localparam stage_ctrl_t CTRL_STALL  = '{freeze_pc: 1'b1, freeze_if_id: 1'b1,
                                          bubble_id_exe: 1'b1, flush_if_id: 1'b0,
                                          freeze_back: 1'b0};

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Stall-source inputs and stage-control outputs between the pipeline datapath
// (master) and the stall sequencer (slave).
interface pipeline_stall_ctrl_if;
  logic hazard_detected;
  logic branch_taken;
  logic mem_req;
  logic mem_ready;
  logic freeze_pc;
  logic freeze_if_id;
  logic bubble_id_exe;
  logic flush_if_id;
  logic freeze_back;

  modport master (
    output hazard_detected, branch_taken, mem_req, mem_ready,
    input  freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_back
  );

  modport slave (
    input  hazard_detected, branch_taken, mem_req, mem_ready,
    output freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_back
  );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  // Count up to all-ones and stick there until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (inc && cnt != MAX)   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Freeze/flush sequencer for the 5-stage pipe. Resolves memory wait, branch
// flush and hazard stall (in that priority) into stage controls, tracks long
// memory waits with a timeout FSM, and keeps stall/flush perf counters.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_cnt,
  pipeline_stall_ctrl_if.slave  sif,
  output logic                  mem_timeout,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] TO_FIRST = TO_W'(1);

  stall_state_e    state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            mwait;
  logic            flush;
  logic            hazard;
  stage_ctrl_t     ctrl;

  // State, timeout counter and sticky fatal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      to_cnt_q    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      if (state_d == HALT) mem_timeout <= 1'b1;
    end
  end

  // Next state and timeout counting. The entry cycle (still in RUN) counts as
  // the first wait cycle, so MEM_WAIT is occupied for at most MEM_TIMEOUT cycles.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    mwait    = 1'b0;
    case (state_q)
      RUN: begin
        mwait = sif.mem_req & ~sif.mem_ready;
        if (mwait) begin
          state_d  = MEM_WAIT;
          to_cnt_d = TO_FIRST;
        end
      end
      MEM_WAIT: begin
        // The request is already latched in MEM; only ready matters here.
        mwait = ~sif.mem_ready;
        if (!mwait)                    state_d  = RUN;
        else if (to_cnt_q == TO_LIMIT) state_d  = HALT;
        else                           to_cnt_d = to_cnt_q + 1'b1;
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // Priority decode of the stage controls; HALT overrides every input.
  always_comb begin
    flush  = 1'b0;
    hazard = 1'b0;
    ctrl   = CTRL_IDLE;
    if (state_q == RUN || state_q == MEM_WAIT) begin
      // A hazard under a taken branch belongs to a squashed instruction.
      flush  = ~mwait & sif.branch_taken;
      hazard = ~mwait & ~sif.branch_taken & sif.hazard_detected;
    end
    if (state_q == HALT || mwait) ctrl = CTRL_FREEZE;
    else if (flush)               ctrl = CTRL_FLUSH;
    else if (hazard)              ctrl = CTRL_STALL;
  end

  assign sif.freeze_pc     = ctrl.freeze_pc;
  assign sif.freeze_if_id  = ctrl.freeze_if_id;
  assign sif.bubble_id_exe = ctrl.bubble_id_exe;
  assign sif.flush_if_id   = ctrl.flush_if_id;
  assign sif.freeze_back   = ctrl.freeze_back;
  assign state_o           = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl.freeze_pc),
    .clr   (clr_cnt),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush),
    .clr   (clr_cnt),
    .cnt   (flush_cnt)
  );

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

- Central freeze/flush sequencer for the 5-stage pipeline.
- Merges three stall sources into one priority-resolved set of stage controls:
  - `hazard_detected` from the combinational hazard detector;
  - `branch_taken` from EXE;
  - the MEM-stage memory handshake.
- Tracks multi-cycle memory waits with a timeout FSM and keeps saturating stall/flush performance counters.
- Sits in the top-level pipeline beside the hazard detector and drives the pipeline-register enables and clears.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255: cycles in MEM_WAIT before fatal halt (1..2^TO_W-1).
- `TO_W`, 8: width of the timeout counter.
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `hazard_detected`  in  1  RAW hazard from the hazard detector, same cycle.
- `branch_taken`  in  1  taken branch resolved in EXE.
- `mem_req`  in  1  MEM stage holds a valid load/store.
- `mem_ready`  in  1  memory completes the MEM-stage access this cycle.
- `clr_cnt`  in  1  synchronous clear of both performance counters.
- `freeze_pc`  out  1  hold PC.
- `freeze_if_id`  out  1  hold IF/ID register.
- `bubble_id_exe`  out  1  load NOP (WB_EN=0, MEM_R/W=0) into ID/EXE.
- `flush_if_id`  out  1  clear IF/ID register.
- `freeze_back`  out  1  hold ID/EXE, EXE/MEM and MEM/WB registers.
- `mem_timeout`  out  1  sticky fatal flag.
- `state_o`  out  2  current FSM state, for debug.
- `stall_cnt`  out  CNT_W  cycles with `freeze_pc`=1, saturating.
- `flush_cnt`  out  CNT_W  branch flushes taken, saturating.

## Operation
FSM states: `RUN`=0, `MEM_WAIT`=1, `HALT`=2. Encoding 3 is illegal and recovers to `RUN`.

Per-cycle control decode is combinational from state and inputs. Priority, highest first:

- **mwait** (`mem_req` & !`mem_ready` in `RUN`, or !`mem_ready` in `MEM_WAIT`):
  - `freeze_pc`=`freeze_if_id`=`freeze_back`=1.
  - `bubble_id_exe`=`flush_if_id`=0.
  - `branch_taken` and `hazard_detected` are ignored.
- **flush** (`branch_taken`, no mwait):
  - `flush_if_id`=1 and `bubble_id_exe`=1, which squashes both wrong-path instructions.
  - `freeze_pc`=0 so the target is fetched.
  - A hazard raised in the same cycle is ignored because its instruction is squashed.
- **hazard** (`hazard_detected`, no mwait, no flush): `freeze_pc`=`freeze_if_id`=`bubble_id_exe`=1.
- Otherwise all controls are 0.

State transitions:
- `RUN` → `MEM_WAIT` on `mem_req` & !`mem_ready`. The timeout counter loads 1.
- `MEM_WAIT`:
  - `mem_ready`=1 → `RUN`. In that exit cycle `freeze_back`=0 and flush/hazard are decoded normally.
  - Otherwise the timeout counter increments. When counter == `MEM_TIMEOUT` and still !`mem_ready` → `HALT`.
- `HALT`:
  - `freeze_pc`, `freeze_if_id` and `freeze_back` are held at 1 and `mem_timeout`=1.
  - All inputs are ignored. Only `rst_n` exits.

Counters:
- `stall_cnt` increments in every cycle with `freeze_pc`=1, including in `HALT`.
- `flush_cnt` increments in every flush-priority cycle.
- Both saturate at 2^CNT_W-1.
- `clr_cnt` zeroes both and takes priority over an increment in the same cycle.

## Timing
- Stage controls are combinational with zero latency. They are valid in the same cycle as the causing input.
- Registered items (`state_o`, `mem_timeout`, counters) update at the next rising edge.
- On reset:
  - state=`RUN`, timeout counter=0, `mem_timeout`=0, `stall_cnt`=`flush_cnt`=0.
  - With inputs low, all stage controls are 0.
- Reset mid-wait or in `HALT` returns to `RUN` asynchronously. The memory request must be reissued by upstream.
- A `mem_req` with `mem_ready` already high in `RUN` never leaves `RUN` and causes no freeze.
- Maximum time in `MEM_WAIT` is `MEM_TIMEOUT` cycles.
- `mem_timeout` rises on the edge after the last counted cycle.

## Structure
- The shared pipeline package holds:
  - the state enum (`RUN`, `MEM_WAIT`, `HALT`, 2 bits);
  - `CTRL_W` and the default `MEM_TIMEOUT`;
  - the NOP control-word constant used by `bubble_id_exe` consumers.
- One natural sub-module is `sat_counter` (width parameter, inc, clr), instantiated twice for the performance counters.
- FSM and priority decode stay in the top module.

## Test plan
- **Reset:** assert `rst_n`=0 mid-`MEM_WAIT` → all outputs 0, `state_o`=0, counters 0, with no clock edge needed.
- **Hazard stall:** `hazard_detected`=1 for 2 cycles → `freeze_pc`, `freeze_if_id` and `bubble_id_exe` are 1 in exactly those 2 cycles; `stall_cnt`=2.
- **Branch over hazard:** `branch_taken`=1 and `hazard_detected`=1 together → `flush_if_id`=1, `bubble_id_exe`=1, `freeze_pc`=0; `flush_cnt`=1, `stall_cnt` unchanged.
- **Memory wait:**
  - `mem_req`=1 with `mem_ready` low for 3 cycles, then high → `freeze_back`=1 for 3 cycles, 0 in the ready cycle.
  - `state_o` sequence: 0,1,1,1,0.
  - A `branch_taken` pulse during the wait is ignored; `flush_cnt` stays 0.
- **Timeout:** `MEM_TIMEOUT`=4, `mem_req`=1, `mem_ready`=0 held → `state_o`=2 and `mem_timeout`=1 after the 4th wait cycle; outputs stay frozen despite later `mem_ready`=1 until `rst_n` pulses.
- **Saturation and clear:** `CNT_W`=3, hazard held 10 cycles → `stall_cnt` stops at 7; `clr_cnt`=1 with hazard still high → counter reads 0 next cycle, then resumes counting.
